btn_debounce_pulse: RTL and testbench

Conditions raw push-button inputs (up, down, left, right, centre) for the game controller. Each button is synchronised, debounced and converted into a clean level plus a single-cycle press pulse. The pulses drive the controller's direction inputs, so one physical press produces exactly one cursor move. The block sits between the board pins and the block controller, on the same fast clock as the state register.

---
 rtl/btn_debounce_pulse.sv | 182 ++++++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse
// Push-button conditioner: per-channel 2-flop synchroniser, debounce FSM,
// clean level output and single-cycle press/release pulses.
// Optional feature macro: BTN_AUTO_REPEAT_EN (adds held-button auto-repeat
// pulses). When undefined, each accepted press yields exactly one pulse.

module btn_debounce_pulse #(
    parameter int N_BTN         = 5,
    parameter int DBNC_CYCLES   = 4,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_rel_pulse,
    output logic             any_pulse
);

    localparam int CNT_W = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RCNT_W-1:0] RDELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RPERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [N_BTN-1:0] sync_q1;
    logic [N_BTN-1:0] sync_q2;

    // Two-flop synchroniser; sync_q2 is the only view of the pins used below
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             db_q;
        logic             db_nxt;
        logic             pulse_q;
        logic             pulse_nxt;
        logic             rel_q;
        logic             rel_nxt;
        logic             s;
`ifdef BTN_AUTO_REPEAT_EN
        logic [RCNT_W-1:0] rcnt;
        logic [RCNT_W-1:0] rcnt_nxt;
        logic              rep_started;
        logic              rep_started_nxt;
`endif

        assign s = sync_q2[i];

        // Channel state, debounce counter and registered outputs
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state   <= IDLE;
                cnt     <= '0;
                db_q    <= 1'b0;
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                rcnt        <= '0;
                rep_started <= 1'b0;
`endif
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                db_q    <= db_nxt;
                pulse_q <= pulse_nxt;
                rel_q   <= rel_nxt;
`ifdef BTN_AUTO_REPEAT_EN
                rcnt        <= rcnt_nxt;
                rep_started <= rep_started_nxt;
`endif
            end
        end

        // Debounce FSM: a level change is accepted only after it has been
        // seen for DBNC_CYCLES+1 consecutive synchronised samples
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            db_nxt    = db_q;
            pulse_nxt = 1'b0;
            rel_nxt   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rcnt_nxt        = rcnt;
            rep_started_nxt = rep_started;
`endif
            case (state)
                IDLE: begin
                    db_nxt = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                    rcnt_nxt        = '0;
                    rep_started_nxt = 1'b0;
`endif
                    if (s) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_nxt = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        db_nxt    = 1'b1;
                        pulse_nxt = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        rcnt_nxt        = '0;
                        rep_started_nxt = 1'b0;
`endif
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    db_nxt = 1'b1;
                    if (!s) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = '0;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    if (!rep_started && rcnt == RDELAY_LAST) begin
                        pulse_nxt       = 1'b1;
                        rcnt_nxt        = '0;
                        rep_started_nxt = 1'b1;
                    end else if (rep_started && rcnt == RPERIOD_LAST) begin
                        pulse_nxt = 1'b1;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt + RCNT_W'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    db_nxt = 1'b1;
                    if (s) begin
                        state_nxt = HELD;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        db_nxt    = 1'b0;
                        rel_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        assign btn_db[i]        = db_q;
        assign btn_pulse[i]     = pulse_q;
        assign btn_rel_pulse[i] = rel_q;
    end

    assign any_pulse = |btn_pulse;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse
// Self-checking bench for btn_debounce_pulse. A behavioural model tracks,
// per channel, how many consecutive synchronised samples disagree with the
// accepted level; the level flips once that run reaches DBNC_CYCLES+1.
// Define BTN_AUTO_REPEAT_EN to also exercise the auto-repeat feature.

module tb_btn_debounce_pulse;

    localparam int N     = 5;
    localparam int DBNC  = 4;
    localparam int RDLY  = 10;
    localparam int RPER  = 5;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_db;
    logic [N-1:0] btn_pulse;
    logic [N-1:0] btn_rel_pulse;
    logic         any_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    btn_debounce_pulse #(
        .N_BTN(N), .DBNC_CYCLES(DBNC), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_db(btn_db),
        .btn_pulse(btn_pulse), .btn_rel_pulse(btn_rel_pulse), .any_pulse(any_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [N-1:0] m_q1, m_s, m_db, m_pulse, m_rel;
    int m_run [N];
    int m_hold[N];

    // Behavioural reference: run-length of disagreement between sample and level
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q1 <= '0; m_s <= '0; m_db <= '0; m_pulse <= '0; m_rel <= '0;
            for (int i = 0; i < N; i++) begin
                m_run[i]  <= 0;
                m_hold[i] <= 0;
            end
        end else begin
            m_q1 <= btn_in;
            m_s  <= m_q1;
            for (int i = 0; i < N; i++) begin
                automatic int   run  = m_run[i];
                automatic int   hold = m_hold[i];
                automatic logic db   = m_db[i];
                automatic logic p    = 1'b0;
                automatic logic r    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                if (db && run == 0) begin
                    hold++;
                    if (hold == RDLY || (hold > RDLY && (hold - RDLY) % RPER == 0)) p = 1'b1;
                end
`endif
                if (m_s[i] == db) begin
                    run = 0;
                end else begin
                    run++;
                    if (run == DBNC + 1) begin
                        run = 0;
                        if (!db) begin
                            p    = 1'b1;
                            hold = 0;
                        end else begin
                            r = 1'b1;
                        end
                        db = ~db;
                    end
                end
                m_run[i]   <= run;
                m_hold[i]  <= hold;
                m_db[i]    <= db;
                m_pulse[i] <= p;
                m_rel[i]   <= r;
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        btn_in = '0;
        idle_cycles(3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({btn_db, btn_pulse, btn_rel_pulse, any_pulse} !== 16'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_state got=%h exp=0000",
                         {btn_db, btn_pulse, btn_rel_pulse, any_pulse});
            end
        end
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_single_press;
        int pulse_edge = -1;
        int pulses     = 0;
        int db_edge    = -1;
        btn_in[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_checks++;
            if ({btn_db, btn_pulse, btn_rel_pulse, any_pulse} !== {m_db, m_pulse, m_rel, |m_pulse}) begin
                n_fail++;
                $display("[TB] FAIL single_press edge=%0d got=%h exp=%h", k,
                         {btn_db, btn_pulse, btn_rel_pulse, any_pulse}, {m_db, m_pulse, m_rel, |m_pulse});
            end
            if (btn_pulse[0]) begin pulses++; pulse_edge = k; end
            if (btn_db[0] && db_edge < 0) db_edge = k;
        end
        n_checks++;
        if (pulses != 1 || pulse_edge != 2 + DBNC) begin
            n_fail++;
            $display("[TB] FAIL single_press_latency got pulses=%0d edge=%0d exp pulses=1 edge=%0d",
                     pulses, pulse_edge, 2 + DBNC);
        end
        n_checks++;
        if (db_edge != 2 + DBNC || btn_db !== 5'b00001) begin
            n_fail++;
            $display("[TB] FAIL single_press_db got edge=%0d db=%b exp edge=%0d db=00001",
                     db_edge, btn_db, 2 + DBNC);
        end
        btn_in = '0;
        idle_cycles(12);
    endtask

    task automatic test_glitch;
        int activity = 0;
        for (int k = 0; k < 20; k++) begin
            btn_in[2] = (k < 8) ? ~k[1] : 1'b0;
            @(negedge clk);
            n_checks++;
            if ({btn_db, btn_pulse, btn_rel_pulse, any_pulse} !== {m_db, m_pulse, m_rel, |m_pulse}) begin
                n_fail++;
                $display("[TB] FAIL glitch edge=%0d got=%h exp=%h", k,
                         {btn_db, btn_pulse, btn_rel_pulse, any_pulse}, {m_db, m_pulse, m_rel, |m_pulse});
            end
            if (btn_db[2] || btn_pulse[2] || btn_rel_pulse[2]) activity++;
        end
        n_checks++;
        if (activity != 0) begin
            n_fail++;
            $display("[TB] FAIL glitch_reject got active_cycles=%0d exp=0", activity);
        end
        btn_in = '0;
        idle_cycles(4);
    endtask

    task automatic test_press_release;
        int pulses   = 0;
        int rel_edge = -1;
        int fall_edge = -1;
        btn_in[1] = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k == 29) btn_in[1] = 1'b0;
            n_checks++;
            if ({btn_db, btn_pulse, btn_rel_pulse, any_pulse} !== {m_db, m_pulse, m_rel, |m_pulse}) begin
                n_fail++;
                $display("[TB] FAIL press_release edge=%0d got=%h exp=%h", k,
                         {btn_db, btn_pulse, btn_rel_pulse, any_pulse}, {m_db, m_pulse, m_rel, |m_pulse});
            end
            if (btn_pulse[1]) pulses++;
            if (btn_rel_pulse[1]) rel_edge = k - 30;
            if (k >= 30 && !btn_db[1] && fall_edge < 0) fall_edge = k - 30;
        end
        n_checks++;
        if (pulses != 1 || rel_edge != 2 + DBNC || fall_edge != 2 + DBNC) begin
            n_fail++;
            $display("[TB] FAIL press_release_timing got pulses=%0d rel=%0d fall=%0d exp 1/%0d/%0d",
                     pulses, rel_edge, fall_edge, 2 + DBNC, 2 + DBNC);
        end
        idle_cycles(2);
    endtask

    task automatic test_simultaneous;
        int any_cycles = 0;
        logic [N-1:0] seen = '0;
        btn_in = 5'b01001;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_checks++;
            if ({btn_db, btn_pulse, btn_rel_pulse, any_pulse} !== {m_db, m_pulse, m_rel, |m_pulse}) begin
                n_fail++;
                $display("[TB] FAIL simultaneous edge=%0d got=%h exp=%h", k,
                         {btn_db, btn_pulse, btn_rel_pulse, any_pulse}, {m_db, m_pulse, m_rel, |m_pulse});
            end
            if (any_pulse) any_cycles++;
            if (k == 2 + DBNC) seen = btn_pulse;
        end
        n_checks++;
        if (seen !== 5'b01001 || any_cycles != 1) begin
            n_fail++;
            $display("[TB] FAIL simultaneous_pulse got pulse=%b any_cycles=%0d exp pulse=01001 any_cycles=1",
                     seen, any_cycles);
        end
        btn_in = '0;
        idle_cycles(12);
    endtask

    task automatic test_reset_mid_press;
        int pulses     = 0;
        int pulse_edge = -1;
        btn_in[4] = 1'b1;
        idle_cycles(12);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({btn_db, btn_pulse, btn_rel_pulse, any_pulse} !== 16'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_press_zero got=%h exp=0000",
                         {btn_db, btn_pulse, btn_rel_pulse, any_pulse});
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_checks++;
            if ({btn_db, btn_pulse, btn_rel_pulse, any_pulse} !== {m_db, m_pulse, m_rel, |m_pulse}) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_press edge=%0d got=%h exp=%h", k,
                         {btn_db, btn_pulse, btn_rel_pulse, any_pulse}, {m_db, m_pulse, m_rel, |m_pulse});
            end
            if (btn_pulse[4]) begin pulses++; pulse_edge = k; end
        end
        n_checks++;
        if (pulses != 1 || pulse_edge != 2 + DBNC) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_press_repress got pulses=%0d edge=%0d exp pulses=1 edge=%0d",
                     pulses, pulse_edge, 2 + DBNC);
        end
        btn_in = '0;
        idle_cycles(12);
    endtask

    task automatic test_random;
        int remain[N];
        int errs = 0;
        for (int i = 0; i < N; i++) remain[i] = $urandom_range(1, 9);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            n_checks++;
            if ({btn_db, btn_pulse, btn_rel_pulse, any_pulse} !== {m_db, m_pulse, m_rel, |m_pulse}) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL random cyc=%0d got=%h exp=%h", k,
                             {btn_db, btn_pulse, btn_rel_pulse, any_pulse}, {m_db, m_pulse, m_rel, |m_pulse});
            end
            for (int i = 0; i < N; i++) begin
                remain[i]--;
                if (remain[i] <= 0) begin
                    btn_in[i] = ~btn_in[i];
                    remain[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20))
                                                            : int'($urandom_range(1, 8));
                end
            end
        end
        btn_in = '0;
        idle_cycles(12);
    endtask

`ifdef BTN_AUTO_REPEAT_EN
    task automatic test_auto_repeat;
        int exp_edges[7] = '{6, 16, 21, 26, 31, 36, 41};
        int got_edges[$];
        btn_in[0] = 1'b1;
        for (int k = 0; k < 65; k++) begin
            @(negedge clk);
            if (k == 39) btn_in[0] = 1'b0;
            n_checks++;
            if ({btn_db, btn_pulse, btn_rel_pulse, any_pulse} !== {m_db, m_pulse, m_rel, |m_pulse}) begin
                n_fail++;
                $display("[TB] FAIL auto_repeat edge=%0d got=%h exp=%h", k,
                         {btn_db, btn_pulse, btn_rel_pulse, any_pulse}, {m_db, m_pulse, m_rel, |m_pulse});
            end
            if (btn_pulse[0]) got_edges.push_back(k);
        end
        n_checks++;
        if (got_edges.size() != 7) begin
            n_fail++;
            $display("[TB] FAIL auto_repeat_count got=%0d exp=7", got_edges.size());
        end else begin
            for (int j = 0; j < 7; j++) begin
                n_checks++;
                if (got_edges[j] != exp_edges[j]) begin
                    n_fail++;
                    $display("[TB] FAIL auto_repeat_edge idx=%0d got=%0d exp=%0d", j, got_edges[j], exp_edges[j]);
                end
            end
        end
        idle_cycles(4);
    endtask
`endif

    initial begin
        btn_in = '0;
        rst    = 1'b1;
        test_reset;
        test_single_press;
        test_glitch;
        test_press_release;
        test_simultaneous;
        test_reset_mid_press;
        test_random;
`ifdef BTN_AUTO_REPEAT_EN
        test_auto_repeat;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
